pll_profile_sequencer: RTL and testbench

// Runtime frequency switcher for a reconfigurable Cyclone V PLL; successor to the fixed single-output PLL wrappers.

---
 rtl/pll_profile_sequencer_if.sv | 18 +
 rtl/pll_profile_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_pll_profile_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pll_profile_sequencer_if.sv
// Avalon-MM management port between the profile sequencer and altera_pll_reconfig.
interface pll_profile_sequencer_if;
   logic [5:0]  mgmt_address;
   logic        mgmt_write;
   logic        mgmt_read;
   logic [31:0] mgmt_writedata;
   logic        mgmt_waitrequest;

   modport master (
      output mgmt_address, mgmt_write, mgmt_read, mgmt_writedata,
      input  mgmt_waitrequest
   );

   modport slave (
      input  mgmt_address, mgmt_write, mgmt_read, mgmt_writedata,
      output mgmt_waitrequest
   );
endinterface

// File: rtl/pll_profile_sequencer.sv
// Runtime PLL frequency switcher: programs one of NUM_PROFILES preset divider sets through
// the reconfig IP mgmt port, starts reconfiguration and waits for lock with bounded retries.
module pll_profile_sequencer #(
   parameter int NUM_PROFILES = 4,
   parameter int NUM_CLOCKS   = 1,
   parameter bit FRACTIONAL   = 1'b1,
   parameter logic [NUM_PROFILES*18-1:0]            PROFILE_N = {NUM_PROFILES{18'h00505}},
   parameter logic [NUM_PROFILES*18-1:0]            PROFILE_M = {NUM_PROFILES{18'h01414}},
   parameter logic [NUM_PROFILES*NUM_CLOCKS*18-1:0] PROFILE_C = {(NUM_PROFILES*NUM_CLOCKS){18'h00303}},
   parameter logic [NUM_PROFILES*32-1:0]            PROFILE_K = {NUM_PROFILES{32'h0}},
   parameter int LOCK_TIMEOUT = 65535,
   parameter int MAX_RETRY    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic [3:0]  req_profile,
   output logic        req_ready,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [3:0]  active_profile,
   input  logic        pll_locked,
   pll_profile_sequencer_if.master mgmt
);
   localparam int CW = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1;
   localparam int TW = $clog2(LOCK_TIMEOUT + 4) + 1;
   localparam int RW = $clog2(MAX_RETRY + 1) + 1;
   localparam logic [CW-1:0] CLAST = CW'(NUM_CLOCKS - 1);
   localparam logic [TW-1:0] TMAX  = TW'(LOCK_TIMEOUT + 3);
   localparam logic [TW-1:0] TIGN  = TW'(4);
   localparam logic [RW-1:0] RMAX  = RW'(MAX_RETRY);
   localparam logic [4:0]    NPROF = 5'(NUM_PROFILES);

   typedef enum logic [3:0] {
      S_IDLE, S_ERR, S_MODE, S_WR_N, S_WR_M, S_WR_C, S_WR_K, S_START, S_WAIT_LOCK
   } state_e;

   state_e        state_q, state_d;
   logic          gap_q, gap_d;
   logic [CW-1:0] cidx_q, cidx_d;
   logic [3:0]    prof_q, prof_d;
   logic [RW-1:0] retry_q, retry_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
   logic [3:0]    active_q, active_d;
   logic          wr_q, wr_d;
   logic [5:0]    addr_q, addr_d;
   logic [31:0]   data_q, data_d;
   logic [1:0]    lock_sync_q, lock_sync_d;
   logic          launch;

   // {address, writedata} of the register write issued in state s
   function automatic logic [37:0] wr_word(state_e s, logic [3:0] p, logic [CW-1:0] c);
      int pi;
      int ci;
      logic [5:0]  a;
      logic [31:0] d;
      pi = int'(p);
      ci = int'(c);
      a  = 6'h00;
      d  = 32'h0;
      case (s)
         S_WR_N:  begin a = 6'h03; d = {14'b0, PROFILE_N[pi*18 +: 18]}; end
         S_WR_M:  begin a = 6'h04; d = {14'b0, PROFILE_M[pi*18 +: 18]}; end
         S_WR_C:  begin a = 6'h05; d = {9'b0, 5'(c), PROFILE_C[(pi*NUM_CLOCKS+ci)*18 +: 18]}; end
         S_WR_K:  begin a = 6'h07; d = PROFILE_K[pi*32 +: 32]; end
         S_START: a = 6'h02;
         default: ;
      endcase
      return {a, d};
   endfunction

   always_comb begin
      state_d     = state_q;
      gap_d       = gap_q;
      cidx_d      = cidx_q;
      prof_d      = prof_q;
      retry_d     = retry_q;
      tcnt_d      = tcnt_q;
      done_d      = 1'b0;
      error_d     = error_q;
      active_d    = active_q;
      wr_d        = wr_q;
      addr_d      = addr_q;
      data_d      = data_q;
      lock_sync_d = {lock_sync_q[0], pll_locked};
      launch      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               error_d = 1'b0;
               retry_d = '0;
               if ({1'b0, req_profile} >= NPROF) begin
                  error_d = 1'b1;
                  state_d = S_ERR;
               end else begin
                  prof_d  = req_profile;
                  cidx_d  = '0;
                  state_d = S_MODE;
                  launch  = 1'b1;
               end
            end
         end
         S_ERR: state_d = S_IDLE;
         S_WAIT_LOCK: begin
            // lock drops during reconfig, so the first few synchronised samples are stale
            if (tcnt_q >= TIGN && lock_sync_q[1]) begin
               done_d   = 1'b1;
               active_d = prof_q;
               state_d  = S_IDLE;
            end else if (tcnt_q >= TMAX) begin
               if (retry_q < RMAX) begin
                  retry_d = retry_q + RW'(1);
                  cidx_d  = '0;
                  state_d = S_MODE;
                  launch  = 1'b1;
               end else begin
                  error_d = 1'b1;
                  state_d = S_IDLE;
               end
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         default: begin
            if (!gap_q) begin
               if (!mgmt.mgmt_waitrequest) begin
                  wr_d  = 1'b0;
                  gap_d = 1'b1;
               end
            end else begin
               gap_d = 1'b0;
               if (state_q == S_START) begin
                  state_d = S_WAIT_LOCK;
                  tcnt_d  = '0;
               end else begin
                  launch = 1'b1;
                  case (state_q)
                     S_MODE: state_d = S_WR_N;
                     S_WR_N: state_d = S_WR_M;
                     S_WR_M: state_d = S_WR_C;
                     S_WR_C: begin
                        if (cidx_q == CLAST) state_d = FRACTIONAL ? S_WR_K : S_START;
                        else                 cidx_d  = cidx_q + CW'(1);
                     end
                     default: state_d = S_START;
                  endcase
               end
            end
         end
      endcase

      if (launch) begin
         wr_d             = 1'b1;
         {addr_d, data_d} = wr_word(state_d, prof_d, cidx_d);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         gap_q       <= 1'b0;
         cidx_q      <= '0;
         prof_q      <= '0;
         retry_q     <= '0;
         tcnt_q      <= '0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         active_q    <= '0;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         lock_sync_q <= '0;
      end else begin
         state_q     <= state_d;
         gap_q       <= gap_d;
         cidx_q      <= cidx_d;
         prof_q      <= prof_d;
         retry_q     <= retry_d;
         tcnt_q      <= tcnt_d;
         done_q      <= done_d;
         error_q     <= error_d;
         active_q    <= active_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         lock_sync_q <= lock_sync_d;
      end
   end

   assign req_ready           = (state_q == S_IDLE);
   assign busy                = (state_q != S_IDLE);
   assign done                = done_q;
   assign error               = error_q;
   assign active_profile      = active_q;
   assign mgmt.mgmt_write     = wr_q;
   assign mgmt.mgmt_address   = addr_q;
   assign mgmt.mgmt_writedata = data_q;
   assign mgmt.mgmt_read      = 1'b0;
endmodule

// File: tb/tb_pll_profile_sequencer.sv
// Directed bench for pll_profile_sequencer: table of request vectors plus a mid-sequence reset case.
module tb_pll_profile_sequencer;
   localparam int NP = 4;
   localparam int NC = 2;
   localparam logic [NP*18-1:0] P_N = {18'h00404, 18'h00303, 18'h00202, 18'h00101};
   localparam logic [NP*18-1:0] P_M = {18'h02020, 18'h01818, 18'h01010, 18'h20808};
   localparam logic [NP*NC*18-1:0] P_C = {18'h00808, 18'h00707, 18'h00606, 18'h00505,
                                          18'h10404, 18'h00303, 18'h00202, 18'h00101};
   localparam logic [NP*32-1:0] P_K = {32'hDDDD0004, 32'hCCCC0003, 32'h80000001, 32'hAAAA0000};

   logic       clk;
   logic       rst_n;
   logic       req_valid;
   logic [3:0] req_profile;
   logic       req_ready, busy, done, error;
   logic [3:0] active_profile;
   logic       pll_locked;

   pll_profile_sequencer_if mif();

   pll_profile_sequencer #(
      .NUM_PROFILES(NP), .NUM_CLOCKS(NC), .FRACTIONAL(1'b1),
      .PROFILE_N(P_N), .PROFILE_M(P_M), .PROFILE_C(P_C), .PROFILE_K(P_K),
      .LOCK_TIMEOUT(100), .MAX_RETRY(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_profile(req_profile),
      .req_ready(req_ready), .busy(busy), .done(done), .error(error),
      .active_profile(active_profile), .pll_locked(pll_locked), .mgmt(mif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] prof;
      int         lmode;   // 0 never lock, 1 lock held, 2 lock 10 after START, 3 fail first START
      int         stall;   // waitrequest cycles on the WR_M write
      int         nwr;
      int         nstart;
      int         ndone;
      logic       err;
      logic [3:0] act;
      int         lat;     // accept->done cycles, -1 = not checked
      bit         chk_seq;
   } vec_t;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int wr_cnt, start_cnt, done_cnt, stall_left, lmode, lock_at, acc_cyc, done_cyc;
   int ready_busy_viol = 0;
   bit prev_stall = 1'b0;
   logic [5:0]  prev_addr;
   logic [31:0] prev_data;
   logic [37:0] wq[$];
   logic [37:0] exp_wr[7];
   vec_t vt[6];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   // Reconfig IP / PLL model plus bus monitor, all evaluated on the falling edge
   initial begin
      mif.mgmt_waitrequest = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (lock_at >= 0 && cyc >= lock_at) pll_locked = 1'b1;
         if (rst_n && mif.mgmt_write && mif.mgmt_address == 6'h04 && stall_left > 0) begin
            mif.mgmt_waitrequest = 1'b1;
            stall_left--;
         end else begin
            mif.mgmt_waitrequest = 1'b0;
         end
         if (prev_stall)
            check("stall_hold", {mif.mgmt_write, mif.mgmt_address, mif.mgmt_writedata},
                  {1'b1, prev_addr, prev_data});
         prev_stall = rst_n && mif.mgmt_write && mif.mgmt_waitrequest;
         prev_addr  = mif.mgmt_address;
         prev_data  = mif.mgmt_writedata;
         if (rst_n && mif.mgmt_write && !mif.mgmt_waitrequest) begin
            wq.push_back({mif.mgmt_address, mif.mgmt_writedata});
            wr_cnt++;
            if (mif.mgmt_address == 6'h02) begin
               start_cnt++;
               if (lmode != 1) pll_locked = 1'b0;
               if (lmode == 2 || (lmode == 3 && start_cnt >= 2)) lock_at = cyc + 10;
               else lock_at = -1;
            end
         end
         if (rst_n && req_valid && req_ready) acc_cyc = cyc;
         if (rst_n && done) begin done_cnt++; done_cyc = cyc; end
         if (busy && req_ready) ready_busy_viol++;
      end
   end

   task automatic run_vec(input vec_t v, input string nm);
      int n;
      @(posedge clk); #1;
      wr_cnt = 0; start_cnt = 0; done_cnt = 0; wq.delete();
      stall_left = v.stall; lmode = v.lmode; lock_at = -1;
      acc_cyc = -1; done_cyc = -1;
      pll_locked = (v.lmode == 1);
      req_valid = 1'b1; req_profile = v.prof;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (busy && n < 3000) begin @(posedge clk); #1; n++; end
      check({nm, "_busy_bound"}, (n >= 3000), 0);
      repeat (3) @(posedge clk);
      #1;
      check({nm, "_writes"}, wr_cnt, v.nwr);
      check({nm, "_starts"}, start_cnt, v.nstart);
      check({nm, "_done"}, done_cnt, v.ndone);
      check({nm, "_error"}, error, v.err);
      check({nm, "_active"}, active_profile, v.act);
      if (v.lat >= 0) check({nm, "_latency"}, done_cyc - acc_cyc, v.lat);
      if (v.chk_seq) begin
         for (int k = 0; k < 7; k++)
            check($sformatf("%s_wr%0d", nm, k), (wq.size() > k) ? wq[k] : 38'h3F_FFFFFFFF, exp_wr[k]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      bit found;
      exp_wr[0] = {6'h00, 32'h00000000};
      exp_wr[1] = {6'h03, 32'h00000202};
      exp_wr[2] = {6'h04, 32'h00001010};
      exp_wr[3] = {6'h05, 32'h00000303};
      exp_wr[4] = {6'h05, 32'h00050404};
      exp_wr[5] = {6'h07, 32'h80000001};
      exp_wr[6] = {6'h02, 32'h00000000};
      //            prof  lm st nwr ns nd err   act   lat seq
      vt[0] = '{4'd1, 2, 0,  7, 1, 1, 1'b0, 4'd1, -1, 1'b1};
      vt[1] = '{4'd2, 1, 0,  7, 1, 1, 1'b0, 4'd2, 20, 1'b0};
      vt[2] = '{4'd3, 2, 5,  7, 1, 1, 1'b0, 4'd3, -1, 1'b0};
      vt[3] = '{4'd0, 0, 0, 21, 3, 0, 1'b1, 4'd3, -1, 1'b0};
      vt[4] = '{4'd4, 0, 0,  0, 0, 0, 1'b1, 4'd3, -1, 1'b0};
      vt[5] = '{4'd1, 3, 0, 14, 2, 1, 1'b0, 4'd1, -1, 1'b0};

      wr_cnt = 0; start_cnt = 0; done_cnt = 0; stall_left = 0; lmode = 0; lock_at = -1;
      acc_cyc = -1; done_cyc = -1;
      rst_n = 1'b0; req_valid = 1'b0; req_profile = 4'd0; pll_locked = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready", req_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done_error", {done, error}, 0);
      check("rst_active", active_profile, 0);
      check("rst_mgmt", {mif.mgmt_write, mif.mgmt_read, mif.mgmt_address, mif.mgmt_writedata}, 0);

      for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("vec%0d", i));

      // reset asserted while the C-counter writes are in flight
      @(posedge clk); #1;
      lmode = 1; pll_locked = 1'b1; stall_left = 0; lock_at = -1;
      req_valid = 1'b1; req_profile = 4'd2;
      @(posedge clk); #1;
      req_valid = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 100 && !found; n++) begin
         @(negedge clk);
         if (mif.mgmt_write && mif.mgmt_address == 6'h05) found = 1'b1;
      end
      check("rst_wrc_reached", found, 1);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_mgmt", {mif.mgmt_write, mif.mgmt_address, mif.mgmt_writedata}, 0);
      check("midrst_ready_busy", {req_ready, busy}, 2'b10);
      check("midrst_done_error", {done, error}, 0);
      check("midrst_active", active_profile, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_vec('{4'd2, 1, 0, 7, 1, 1, 1'b0, 4'd2, 20, 1'b0}, "after_rst");

      check("mgmt_read_zero", mif.mgmt_read, 0);
      check("ready_while_busy", ready_busy_viol, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
